// File: rtl/wb_arb2.sv
// wb_arb2: two-master Wishbone classic arbiter with one-idle-cycle handover and a bus-timeout watchdog.
// Define WB_ARB2_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise m1 has fixed priority.
module wb_arb2 #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8,
    localparam int unsigned SW     = DW / 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    input  logic          m0_we_i,
    input  logic [SW-1:0] m0_sel_i,
    input  logic          m0_stb_i,
    input  logic          m0_cyc_i,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    input  logic          m1_we_i,
    input  logic [SW-1:0] m1_sel_i,
    input  logic          m1_stb_i,
    input  logic          m1_cyc_i,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    output logic          s_we_o,
    output logic [SW-1:0] s_sel_o,
    output logic          s_stb_o,
    output logic          s_cyc_o,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    output logic [1:0]    gnt_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    localparam bit            TMO_EN  = (TIMEOUT != 0);
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [1:0]    gnt;
    logic          stalled;
    logic          tmo_err;

`ifdef WB_ARB2_ROUND_ROBIN_EN
    // 0 = m0 owned the last grant, 1 = m1
    logic last_q, last_d;
`endif

    assign gnt   = {state_q == GNT1, state_q == GNT0};
    assign gnt_o = gnt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
`ifdef WB_ARB2_ROUND_ROBIN_EN
                    state_d = last_q ? GNT0 : GNT1;
`else
                    state_d = GNT1;
`endif
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end
            end
            GNT0:    if (!m0_cyc_i) state_d = IDLE;
            GNT1:    if (!m1_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef WB_ARB2_ROUND_ROBIN_EN
    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && state_d == GNT0) last_d = 1'b0;
        if (state_q == IDLE && state_d == GNT1) last_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) last_q <= 1'b0;
        else          last_q <= last_d;
    end
`endif

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        if (gnt[0]) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_stb_o = m0_stb_i;
            s_cyc_o = m0_cyc_i;
        end else if (gnt[1]) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_stb_o = m1_stb_i;
            s_cyc_o = m1_cyc_i;
        end
    end

    // A timeout firing in the same cycle as a slave ack is suppressed: the ack wins.
    assign stalled = s_stb_o && !s_ack_i && !s_err_i;
    assign tmo_err = TMO_EN && stalled && (tmo_cnt_q == TMO_LIM);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (!TMO_EN || state_q == IDLE || s_ack_i || s_err_i || tmo_err) begin
            tmo_cnt_d = '0;
        end else if (s_stb_o) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign m0_ack_o = s_ack_i & gnt[0];
    assign m1_ack_o = s_ack_i & gnt[1];
    assign m0_err_o = (s_err_i | tmo_err) & gnt[0];
    assign m1_err_o = (s_err_i | tmo_err) & gnt[1];
    assign m0_dat_o = gnt[0] ? s_dat_i : '0;
    assign m1_dat_o = gnt[1] ? s_dat_i : '0;

endmodule

// File: tb/tb_wb_arb2.sv
// Directed self-checking bench for wb_arb2 (TIMEOUT = 4); expected results are queued at stimulus time
// and compared when the arbiter responds. Handles both WB_ARB2_ROUND_ROBIN_EN settings.
module tb_wb_arb2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m0_adr, m0_dat_w, m0_dat_r, m1_adr, m1_dat_w, m1_dat_r;
    logic        m0_we, m0_stb, m0_cyc, m0_ack, m0_err;
    logic        m1_we, m1_stb, m1_cyc, m1_ack, m1_err;
    logic [3:0]  m0_sel, m1_sel, s_sel;
    logic [31:0] s_adr, s_dat_w, s_dat_r;
    logic        s_we, s_stb, s_cyc, s_ack, s_err;
    logic [1:0]  gnt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    wb_arb2 #(.AW(32), .DW(32), .TIMEOUT(4), .TW(8)) dut (
        .wb_clk_i(clk),      .wb_rst_i(rst),
        .m0_adr_i(m0_adr),   .m0_dat_i(m0_dat_w), .m0_dat_o(m0_dat_r),
        .m0_we_i(m0_we),     .m0_sel_i(m0_sel),   .m0_stb_i(m0_stb),
        .m0_cyc_i(m0_cyc),   .m0_ack_o(m0_ack),   .m0_err_o(m0_err),
        .m1_adr_i(m1_adr),   .m1_dat_i(m1_dat_w), .m1_dat_o(m1_dat_r),
        .m1_we_i(m1_we),     .m1_sel_i(m1_sel),   .m1_stb_i(m1_stb),
        .m1_cyc_i(m1_cyc),   .m1_ack_o(m1_ack),   .m1_err_o(m1_err),
        .s_adr_o(s_adr),     .s_dat_o(s_dat_w),   .s_dat_i(s_dat_r),
        .s_we_o(s_we),       .s_sel_o(s_sel),     .s_stb_o(s_stb),
        .s_cyc_o(s_cyc),     .s_ack_i(s_ack),     .s_err_i(s_err),
        .gnt_o(gnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int k_seen;
        int ack_seen;
        logic [31:0] e;

        m0_adr = 32'h5; m0_dat_w = '0; m0_we = 0; m0_sel = '0; m0_stb = 0; m0_cyc = 0;
        m1_adr = '0;    m1_dat_w = '0; m1_we = 0; m1_sel = '0; m1_stb = 0; m1_cyc = 0;
        s_dat_r = 32'h1234_5678; s_ack = 0; s_err = 0;

        // reset state
        repeat (2) tick;
        smp;
        chk("rst_gnt",    32'(gnt),      32'd0);
        chk("rst_s_cyc",  32'(s_cyc),    32'd0);
        chk("rst_s_adr",  s_adr,         32'd0);
        chk("rst_m0_ack", 32'(m0_ack),   32'd0);
        chk("rst_m0_dat", m0_dat_r,      32'd0);
        tick;
        rst = 0;

        // single m0 read, slave acks 2 cycles after strobe
        tick;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100; m0_sel = 4'hF;
        exp_q.push_back(32'hDEAD_BEEF);
        smp;
        chk("t1_latency_cyc", 32'(s_cyc), 32'd0);
        tick; smp;
        chk("t1_s_cyc", 32'(s_cyc), 32'd1);
        chk("t1_gnt",   32'(gnt),   32'd1);
        chk("t1_s_adr", s_adr,      32'h100);
        tick; smp;
        chk("t1_early_ack", 32'(m0_ack), 32'd0);
        tick;
        s_ack = 1; s_dat_r = 32'hDEAD_BEEF;
        smp;
        chk("t1_ack",    32'(m0_ack), 32'd1);
        chk("t1_dat",    m0_dat_r,    exp_q.pop_front());
        chk("t1_m1_ack", 32'(m1_ack), 32'd0);
        chk("t1_m1_dat", m1_dat_r,    32'd0);
        tick;
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        smp;
        chk("t1_ack_pulse", 32'(m0_ack), 32'd0);
        tick; smp;
        chk("t1_idle", 32'(gnt), 32'd0);

        // simultaneous requests, three rounds
`ifdef WB_ARB2_ROUND_ROBIN_EN
        exp_q.push_back(32'd2); exp_q.push_back(32'd1); exp_q.push_back(32'd2);
`else
        exp_q.push_back(32'd2); exp_q.push_back(32'd2); exp_q.push_back(32'd2);
`endif
        for (int r = 0; r < 3; r++) begin
            tick;
            m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
            smp;
            chk("t3_latency", 32'(gnt), 32'd0);
            tick;
            s_ack = 1; s_dat_r = 32'hA0 + 32'(r);
            smp;
            e = exp_q.pop_front();
            chk("t3_gnt", 32'(gnt), e);
            chk("t3_winner_ack", 32'(e[0] ? m0_ack : m1_ack), 32'd1);
            chk("t3_loser_ack",  32'(e[0] ? m1_ack : m0_ack), 32'd0);
            tick;
            s_ack = 0; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
            tick; smp;
            chk("t3_idle", 32'(gnt), 32'd0);
        end

        // m1 write
        tick;
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h10; m1_dat_w = 32'h41; m1_sel = 4'b0001;
        smp;
        chk("t2_latency", 32'(gnt), 32'd0);
        tick; smp;
        chk("t2_gnt",   32'(gnt),   32'd2);
        chk("t2_s_adr", s_adr,      32'h10);
        chk("t2_s_dat", s_dat_w,    32'h41);
        chk("t2_s_sel", 32'(s_sel), 32'd1);
        chk("t2_s_we",  32'(s_we),  32'd1);
        tick;
        s_ack = 1;
        smp;
        chk("t2_m1_ack", 32'(m1_ack), 32'd1);
        chk("t2_m0_ack", 32'(m0_ack), 32'd0);
        tick;
        s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
        smp;
        chk("t2_gnt_hold", 32'(gnt),   32'd2);
        chk("t2_s_cyc",    32'(s_cyc), 32'd0);
        tick; smp;
        chk("t2_idle", 32'(gnt), 32'd0);

        // slave error routed to m1 only
        tick;
        m1_cyc = 1; m1_stb = 1;
        tick;
        s_err = 1;
        smp;
        chk("serr_m1", 32'(m1_err), 32'd1);
        chk("serr_m0", 32'(m0_err), 32'd0);
        tick;
        s_err = 0; m1_cyc = 0; m1_stb = 0;
        tick;

        // watchdog: slave never acks
        tick;
        m0_cyc = 1; m0_stb = 1;
        exp_q.push_back(32'd4);
        tick;
        k_seen = -1; ack_seen = 0;
        for (int k = 0; k < 16; k++) begin
            smp;
            if (m0_ack) ack_seen++;
            if (m0_err) begin
                k_seen = k;
                break;
            end
            tick;
        end
        chk("t4_err_cycle", 32'(k_seen),   exp_q.pop_front());
        chk("t4_no_ack",    32'(ack_seen), 32'd0);
        tick; smp;
        chk("t4_err_pulse", 32'(m0_err), 32'd0);
        tick;
        m0_cyc = 0; m0_stb = 0;
        tick;

        // watchdog: ack lands on the cycle the timeout would fire
        tick;
        m0_cyc = 1; m0_stb = 1;
        tick;
        for (int k = 0; k < 4; k++) tick;
        s_ack = 1; s_dat_r = 32'hCAFE_F00D;
        smp;
        chk("t5_ack", 32'(m0_ack), 32'd1);
        chk("t5_err", 32'(m0_err), 32'd0);
        chk("t5_dat", m0_dat_r,    32'hCAFE_F00D);
        tick;
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick;

        // asynchronous reset while m1 owns the bus
        tick;
        m1_cyc = 1; m1_stb = 1;
        tick; smp;
        chk("t6_gnt1", 32'(gnt), 32'd2);
        #2 rst = 1;
        #1;
        chk("t6_rst_gnt",   32'(gnt),   32'd0);
        chk("t6_rst_s_cyc", 32'(s_cyc), 32'd0);
        chk("t6_rst_s_stb", 32'(s_stb), 32'd0);
        tick;
        m1_cyc = 0; m1_stb = 0;
        tick;
        rst = 0;
        tick;
        m0_cyc = 1; m0_stb = 1;
        tick; smp;
        chk("t6_m0_gnt",   32'(gnt),   32'd1);
        chk("t6_m0_s_cyc", 32'(s_cyc), 32'd1);

        // master abort: a late ack reaches no one
        tick;
        m0_cyc = 0; m0_stb = 0;
        tick;
        s_ack = 1;
        smp;
        chk("abort_m0_ack", 32'(m0_ack), 32'd0);
        chk("abort_m1_ack", 32'(m1_ack), 32'd0);
        chk("abort_gnt",    32'(gnt),    32'd0);
        tick;
        s_ack = 0;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
